// File: rtl/rrf_flag_retire_wr_pkg.sv
// Shared types for the flag register-file writer.
//   FLAG_WIDTH     width of one architectural flag vector
//   rrf_flag_wr_t  one pending write: owning thread plus flag value
package rrf_flag_retire_wr_pkg;

    localparam int FLAG_WIDTH = 6;

    typedef struct packed {
        logic                  thread;
        logic [FLAG_WIDTH-1:0] data;
    } rrf_flag_wr_t;

endpackage

// File: rtl/rrf_flag_retire_wr_fifo.sv
// Pending-write buffer between the retire pipe and the RRF write port.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push          append push_data at the tail
//   push_data     entry to append
//   pop           drop the head entry
//   flush_en      invalidate every entry owned by flush_thread
//   flush_thread  thread being flushed
//   head          oldest entry (valid only when empty=0)
//   empty         no entries held
//   count_next    occupancy after this cycle's pop/flush/push
// Each slot has its own valid bit so a flush can drop entries by thread.
// On a flush the surviving entries are compacted to slot 0 in their
// original order; the reordering of storage never shows at the ports.
module rrf_flag_retire_wr_fifo
    import rrf_flag_retire_wr_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  rrf_flag_wr_t     push_data,
    input  logic             pop,
    input  logic             flush_en,
    input  logic             flush_thread,
    output rrf_flag_wr_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count_next
);

    rrf_flag_wr_t     mem   [DEPTH];
    rrf_flag_wr_t     mem_n [DEPTH];
    logic [DEPTH-1:0] vld, vld_n;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CNT_W-1:0] count, count_pre, kept;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        mem_n      = mem;
        vld_n      = vld;
        rd_n       = rd_ptr;
        wr_n       = wr_ptr;
        count_pre  = count;
        kept       = '0;
        idx        = '0;

        if (flush_en) begin
            // Walk oldest to youngest, keeping other-thread entries in order.
            vld_n = '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PTR_W'(k);
                if (vld[idx] && !(pop && k == 0) && mem[idx].thread != flush_thread) begin
                    mem_n[kept[PTR_W-1:0]] = mem[idx];
                    vld_n[kept[PTR_W-1:0]] = 1'b1;
                    kept                   = kept + CNT_W'(1);
                end
            end
            rd_n      = '0;
            wr_n      = kept[PTR_W-1:0];
            count_pre = kept;
        end else if (pop) begin
            vld_n[rd_ptr] = 1'b0;
            rd_n          = rd_ptr + PTR_W'(1);
            count_pre     = count - CNT_W'(1);
        end

        count_next = count_pre;
        if (push) begin
            mem_n[wr_n] = push_data;
            vld_n[wr_n] = 1'b1;
            wr_n        = wr_n + PTR_W'(1);
            count_next  = count_pre + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            rd_ptr <= rd_n;
            wr_ptr <= wr_n;
            count  <= count_next;
            vld    <= vld_n;
        end
    end

    // NOTE: the storage array is deliberately not reset; the valid bits and
    // count alone define which slots hold live data.
    always_ff @(posedge clk) begin
        mem <= mem_n;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    // The stall logic upstream must never let a push land on a full buffer.
    push_not_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count_pre == CNT_W'(DEPTH)));

endmodule

// File: rtl/rrf_flag_retire_wr.sv
// Writer side of the architectural flag register file.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   retire_clkEn    retire stage advances this cycle
//   ret_valid       per-slot retire valid (slot 0 oldest)
//   ret_flag_wen    per-slot flag write
//   ret_flags       per-slot flags, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ret_thread      thread of the whole retire group
//   restore_en      exception/flush flag restore request
//   restore_flush   with restore_en: discard pending writes of restore_thread
//   restore_data    restored flag value
//   restore_thread  thread of the restore
//   retire_stall    retire must hold next cycle
//   write0_data/write0_wen/write_thread  single RRF write port
// DATA_WIDTH must equal FLAG_WIDTH from the package.
module rrf_flag_retire_wr
    import rrf_flag_retire_wr_pkg::*;
#(
    parameter int DATA_WIDTH = FLAG_WIDTH,
    parameter int RET_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          retire_clkEn,
    input  logic [RET_WIDTH-1:0]          ret_valid,
    input  logic [RET_WIDTH-1:0]          ret_flag_wen,
    input  logic [RET_WIDTH*DATA_WIDTH-1:0] ret_flags,
    input  logic                          ret_thread,
    input  logic                          restore_en,
    input  logic                          restore_flush,
    input  logic [DATA_WIDTH-1:0]         restore_data,
    input  logic                          restore_thread,
    output logic                          retire_stall,
    output logic [DATA_WIDTH-1:0]         write0_data,
    output logic                          write0_wen,
    output logic                          write_thread
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  raw_hit, s0_hit, s0_keep, flush_now;
    logic [DATA_WIDTH-1:0] sel_flags;
    logic                  s1_vld, s1_thr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  use_fifo, use_s1, s1_drop, push, pop;
    rrf_flag_wr_t          s1_entry, fifo_head;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      count_next;

    // Youngest flag writer wins: later slots overwrite earlier matches.
    always_comb begin
        raw_hit   = 1'b0;
        sel_flags = '0;
        for (int i = 0; i < RET_WIDTH; i++) begin
            if (ret_valid[i] && ret_flag_wen[i]) begin
                raw_hit   = 1'b1;
                sel_flags = ret_flags[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign flush_now = restore_en & restore_flush;
    assign s0_hit    = raw_hit & retire_clkEn & ~retire_stall;
    // A retire of the thread being flushed in this very cycle is discarded.
    assign s0_keep   = s0_hit & ~(flush_now & (ret_thread == restore_thread));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_thr  <= 1'b0;
        end else begin
            s1_vld <= s0_keep;
            if (s0_keep) begin
                s1_data <= sel_flags;
                s1_thr  <= ret_thread;
            end
        end
    end

    // Port arbitration: restore, then buffered writes, then s1 bypass.
    always_comb begin
        use_fifo = !restore_en && !fifo_empty;
        use_s1   = !restore_en && fifo_empty && s1_vld;
        s1_drop  = flush_now && (s1_thr == restore_thread);
        push     = s1_vld && !use_s1 && !s1_drop;
        pop      = use_fifo;
    end

    assign s1_entry = '{thread: s1_thr, data: s1_data};

    rrf_flag_retire_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (s1_entry),
        .pop         (pop),
        .flush_en    (flush_now),
        .flush_thread(restore_thread),
        .head        (fifo_head),
        .empty       (fifo_empty),
        .count_next  (count_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            write0_wen   <= 1'b0;
            write0_data  <= '0;
            write_thread <= 1'b0;
            retire_stall <= 1'b0;
        end else begin
            // Stalling at DEPTH-1 leaves one slot for the s1 entry already in flight.
            retire_stall <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
            write0_wen   <= restore_en | use_fifo | use_s1;
            if (restore_en) begin
                write0_data  <= restore_data;
                write_thread <= restore_thread;
            end else if (use_fifo) begin
                write0_data  <= fifo_head.data;
                write_thread <= fifo_head.thread;
            end else if (use_s1) begin
                write0_data  <= s1_data;
                write_thread <= s1_thr;
            end
        end
    end

endmodule

// File: tb/tb_rrf_flag_retire_wr.sv
// Directed bench for rrf_flag_retire_wr. A negedge monitor records every
// RRF write as {thread, data}; steps compare that log and the outputs
// against hand-computed values.
module tb_rrf_flag_retire_wr;

    localparam int DW = 6;
    localparam int RW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             retire_clkEn;
    logic [RW-1:0]    ret_valid;
    logic [RW-1:0]    ret_flag_wen;
    logic [RW*DW-1:0] ret_flags;
    logic             ret_thread;
    logic             restore_en;
    logic             restore_flush;
    logic [DW-1:0]    restore_data;
    logic             restore_thread;
    logic             retire_stall;
    logic [DW-1:0]    write0_data;
    logic             write0_wen;
    logic             write_thread;

    always #5 clk = ~clk;

    rrf_flag_retire_wr #(
        .DATA_WIDTH(DW),
        .RET_WIDTH (RW),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .retire_clkEn  (retire_clkEn),
        .ret_valid     (ret_valid),
        .ret_flag_wen  (ret_flag_wen),
        .ret_flags     (ret_flags),
        .ret_thread    (ret_thread),
        .restore_en    (restore_en),
        .restore_flush (restore_flush),
        .restore_data  (restore_data),
        .restore_thread(restore_thread),
        .retire_stall  (retire_stall),
        .write0_data   (write0_data),
        .write0_wen    (write0_wen),
        .write_thread  (write_thread)
    );

    int checks   = 0;
    int failures = 0;
    logic [6:0] wr_q[$];

    always @(negedge clk) begin
        if (!rst && write0_wen) wr_q.push_back({write_thread, write0_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Next logged write must be exp ({thread, data}); an empty log reads as FFFFFFFF.
    task automatic check_wr(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        if (wr_q.size() == 0) got = 32'hFFFF_FFFF;
        else                  got = 32'(wr_q.pop_front());
        check(tag, got, exp);
    endtask

    task automatic clear_ret();
        ret_valid    = '0;
        ret_flag_wen = '0;
        ret_flags    = '0;
        ret_thread   = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic [DW-1:0] f, input logic wen);
        ret_valid[i]          = 1'b1;
        ret_flag_wen[i]       = wen;
        ret_flags[i*DW +: DW] = f;
    endtask

    task automatic restore(input logic en, input logic fl, input logic [DW-1:0] d, input logic thr);
        restore_en     = en;
        restore_flush  = fl;
        restore_data   = d;
        restore_thread = thr;
    endtask

    initial begin
        rst          = 1'b1;
        retire_clkEn = 1'b1;
        clear_ret();
        restore(1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();
        check("reset_wen",    32'(write0_wen),   0);
        check("reset_data",   32'(write0_data),  0);
        check("reset_thread", 32'(write_thread), 0);
        check("reset_stall",  32'(retire_stall), 0);
        rst = 1'b0;
        tick();

        // 1: single writer in slot 2, slot 3 valid without flag write
        wr_q.delete();
        set_slot(2, 6'h15, 1'b1);
        set_slot(3, 6'h2A, 1'b0);
        tick();
        clear_ret();
        check("t1_wen_t1", 32'(write0_wen), 0);
        tick();
        check("t1_wen_t2",  32'(write0_wen),   1);
        check("t1_data_t2", 32'(write0_data),  32'h15);
        check("t1_thr_t2",  32'(write_thread), 0);
        tick();
        check("t1_wen_t3", 32'(write0_wen), 0);
        tick(); tick();
        check_wr("t1_write", 32'h15);
        check("t1_count", 32'(wr_q.size()), 0);

        // 2: youngest flag writer wins
        wr_q.delete();
        set_slot(0, 6'h01, 1'b1);
        set_slot(1, 6'h02, 1'b1);
        set_slot(2, 6'h3F, 1'b0);
        set_slot(3, 6'h08, 1'b1);
        ret_thread = 1'b1;
        tick();
        clear_ret();
        repeat (4) tick();
        check_wr("t2_write", 32'h48);
        check("t2_count", 32'(wr_q.size()), 0);

        // 3: restore beats s1; retire holds its uop while stalled
        wr_q.delete();
        set_slot(0, 6'h11, 1'b1);
        tick();
        clear_ret(); set_slot(0, 6'h12, 1'b1);
        restore(1'b1, 1'b0, 6'h3F, 1'b0);
        tick();
        check("t3_stall_a", 32'(retire_stall), 1);
        restore(1'b0, 1'b0, '0, 1'b0);
        clear_ret(); set_slot(0, 6'h13, 1'b1);
        tick();
        check("t3_stall_b", 32'(retire_stall), 1);
        tick();
        check("t3_stall_c", 32'(retire_stall), 0);
        tick();
        clear_ret();
        repeat (3) tick();
        check_wr("t3_w0", 32'h3F);
        check_wr("t3_w1", 32'h11);
        check_wr("t3_w2", 32'h12);
        check_wr("t3_w3", 32'h13);
        check("t3_count", 32'(wr_q.size()), 0);

        // 4a: flush thr1 drops buffered thr1 entry, s1 thr0 survives
        wr_q.delete();
        set_slot(1, 6'h04, 1'b1); ret_thread = 1'b1;
        tick();
        clear_ret(); set_slot(1, 6'h05, 1'b1); ret_thread = 1'b0;
        restore(1'b1, 1'b0, 6'h3F, 1'b0);
        tick();
        clear_ret();
        restore(1'b1, 1'b1, 6'h00, 1'b1);
        tick();
        restore(1'b0, 1'b0, '0, 1'b0);
        repeat (4) tick();
        check_wr("t4a_w0", 32'h3F);
        check_wr("t4a_w1", 32'h40);
        check_wr("t4a_w2", 32'h05);
        check("t4a_count", 32'(wr_q.size()), 0);

        // 4b: flush thr1 drops s1 thr1, buffered thr0 entry survives
        wr_q.delete();
        set_slot(0, 6'h04, 1'b1); ret_thread = 1'b0;
        tick();
        clear_ret(); set_slot(0, 6'h06, 1'b1); ret_thread = 1'b1;
        restore(1'b1, 1'b0, 6'h3F, 1'b0);
        tick();
        clear_ret();
        restore(1'b1, 1'b1, 6'h00, 1'b1);
        tick();
        restore(1'b0, 1'b0, '0, 1'b0);
        repeat (4) tick();
        check_wr("t4b_w0", 32'h3F);
        check_wr("t4b_w1", 32'h40);
        check_wr("t4b_w2", 32'h04);
        check("t4b_count", 32'(wr_q.size()), 0);

        // 4c: same-thread retire in the flush cycle is dropped
        wr_q.delete();
        set_slot(3, 6'h07, 1'b1); ret_thread = 1'b1;
        restore(1'b1, 1'b1, 6'h00, 1'b1);
        tick();
        clear_ret();
        restore(1'b0, 1'b0, '0, 1'b0);
        repeat (3) tick();
        check_wr("t4c_w0", 32'h40);
        check("t4c_count", 32'(wr_q.size()), 0);

        // 5a: retire_clkEn low gates valid slots
        wr_q.delete();
        retire_clkEn = 1'b0;
        for (int i = 0; i < RW; i++) set_slot(i, 6'h2C, 1'b1);
        tick(); tick();
        clear_ret();
        retire_clkEn = 1'b1;
        repeat (3) tick();
        check("t5a_count", 32'(wr_q.size()), 0);

        // 5b: full buffer with stall ignores retire until drained
        wr_q.delete();
        set_slot(0, 6'h21, 1'b1);
        tick();
        clear_ret(); set_slot(0, 6'h22, 1'b1);
        restore(1'b1, 1'b0, 6'h3F, 1'b0);
        tick();
        clear_ret(); set_slot(0, 6'h23, 1'b1);
        restore(1'b1, 1'b0, 6'h3E, 1'b1);
        tick();
        check("t5b_stall_full", 32'(retire_stall), 1);
        restore(1'b0, 1'b0, '0, 1'b0);
        tick();
        check("t5b_stall_one", 32'(retire_stall), 1);
        tick();
        check("t5b_stall_zero", 32'(retire_stall), 0);
        tick();
        clear_ret();
        repeat (3) tick();
        check_wr("t5b_w0", 32'h3F);
        check_wr("t5b_w1", 32'h7E);
        check_wr("t5b_w2", 32'h21);
        check_wr("t5b_w3", 32'h22);
        check_wr("t5b_w4", 32'h23);
        check("t5b_count", 32'(wr_q.size()), 0);

        // 6: reset with two buffered writes discards them
        set_slot(0, 6'h21, 1'b1);
        tick();
        clear_ret(); set_slot(0, 6'h22, 1'b1);
        restore(1'b1, 1'b0, 6'h3F, 1'b0);
        tick();
        clear_ret();
        restore(1'b1, 1'b0, 6'h3E, 1'b1);
        tick();
        restore(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        check("t6_wen_rst",   32'(write0_wen),   0);
        check("t6_stall_rst", 32'(retire_stall), 0);
        rst = 1'b0;
        wr_q.delete();
        tick();
        check("t6_wen_after", 32'(write0_wen), 0);
        repeat (4) tick();
        check("t6_count", 32'(wr_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
